// File: rtl/nzcv_status_reg.sv
// Registered NZCV status stage: masked flag capture, forwarded condition-code evaluation,
// and a saturating overflow-event counter with a sticky overflow bit.
module nzcv_status_reg #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  input  logic [3:0]       upd_mask,
  input  logic             n_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             z_in,
  input  logic             cond_valid,
  input  logic [3:0]       cond_code,
  output logic             cond_out_valid,
  output logic             cond_true,
  output logic [3:0]       flags,
  output logic             v_sticky,
  output logic [CNT_W-1:0] v_count,
  input  logic             sticky_clr
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [3:0]       FlagsRst = 4'b0001;

  typedef enum logic [3:0] {
    CcEq = 4'd0,  CcNe = 4'd1,  CcCs = 4'd2,  CcCc = 4'd3,
    CcMi = 4'd4,  CcPl = 4'd5,  CcVs = 4'd6,  CcVc = 4'd7,
    CcHi = 4'd8,  CcLs = 4'd9,  CcGe = 4'd10, CcLt = 4'd11,
    CcGt = 4'd12, CcLe = 4'd13, CcAl = 4'd14, CcNv = 4'd15
  } cond_e;

  logic [3:0]       flags_q, flags_d;
  logic             cond_out_valid_q, cond_out_valid_d;
  logic             cond_true_q, cond_true_d;
  logic             v_sticky_q, v_sticky_d;
  logic [CNT_W-1:0] v_count_q, v_count_d;

  logic [3:0] in_flags;
  logic [3:0] eff_flags;
  logic       f_n, f_c, f_v, f_z;
  logic       cond_res;
  logic       v_event;

  assign in_flags = {n_in, c_in, v_in, z_in};
  assign v_event  = upd_valid & upd_mask[1] & v_in;

  // Effective flags forward this cycle's update so a same-cycle condition sees new values.
  always_comb begin
    eff_flags = flags_q;
    if (upd_valid) begin
      eff_flags = (flags_q & ~upd_mask) | (in_flags & upd_mask);
    end
  end

  assign f_n = eff_flags[3];
  assign f_c = eff_flags[2];
  assign f_v = eff_flags[1];
  assign f_z = eff_flags[0];

  always_comb begin
    cond_res = 1'b0;
    unique case (cond_e'(cond_code))
      CcEq: cond_res = f_z;
      CcNe: cond_res = ~f_z;
      CcCs: cond_res = f_c;
      CcCc: cond_res = ~f_c;
      CcMi: cond_res = f_n;
      CcPl: cond_res = ~f_n;
      CcVs: cond_res = f_v;
      CcVc: cond_res = ~f_v;
      CcHi: cond_res = f_c & ~f_z;
      CcLs: cond_res = ~f_c | f_z;
      CcGe: cond_res = (f_n == f_v);
      CcLt: cond_res = (f_n != f_v);
      CcGt: cond_res = ~f_z & (f_n == f_v);
      CcLe: cond_res = f_z | (f_n != f_v);
      CcAl: cond_res = 1'b1;
      CcNv: cond_res = 1'b0;
      default: cond_res = 1'b0;
    endcase
  end

  always_comb begin
    flags_d          = eff_flags;
    cond_out_valid_d = cond_valid;
    cond_true_d      = cond_true_q;
    if (cond_valid) begin
      cond_true_d = cond_res;
    end
  end

  // An event on the same edge as a clear wins: the count restarts at one.
  always_comb begin
    v_sticky_d = v_sticky_q;
    v_count_d  = v_count_q;
    if (v_event) begin
      v_sticky_d = 1'b1;
      if (sticky_clr) begin
        v_count_d = CntOne;
      end else if (v_count_q != CntMax) begin
        v_count_d = v_count_q + CntOne;
      end
    end else if (sticky_clr) begin
      v_sticky_d = 1'b0;
      v_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q          <= FlagsRst;
      cond_out_valid_q <= 1'b0;
      cond_true_q      <= 1'b0;
      v_sticky_q       <= 1'b0;
      v_count_q        <= '0;
    end else begin
      flags_q          <= flags_d;
      cond_out_valid_q <= cond_out_valid_d;
      cond_true_q      <= cond_true_d;
      v_sticky_q       <= v_sticky_d;
      v_count_q        <= v_count_d;
    end
  end

  assign flags          = flags_q;
  assign cond_out_valid = cond_out_valid_q;
  assign cond_true      = cond_true_q;
  assign v_sticky       = v_sticky_q;
  assign v_count        = v_count_q;

endmodule

// File: tb/tb_nzcv_status_reg.sv
// Self-checking bench for nzcv_status_reg: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_nzcv_status_reg;

  localparam int unsigned CNT_W = 2;
  localparam int CntSat = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             upd_valid;
  logic [3:0]       upd_mask;
  logic             n_in, c_in, v_in, z_in;
  logic             cond_valid;
  logic [3:0]       cond_code;
  logic             cond_out_valid;
  logic             cond_true;
  logic [3:0]       flags;
  logic             v_sticky;
  logic [CNT_W-1:0] v_count;
  logic             sticky_clr;

  int checks = 0;
  int failures = 0;

  nzcv_status_reg #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .upd_valid      (upd_valid),
    .upd_mask       (upd_mask),
    .n_in           (n_in),
    .c_in           (c_in),
    .v_in           (v_in),
    .z_in           (z_in),
    .cond_valid     (cond_valid),
    .cond_code      (cond_code),
    .cond_out_valid (cond_out_valid),
    .cond_true      (cond_true),
    .flags          (flags),
    .v_sticky       (v_sticky),
    .v_count        (v_count),
    .sticky_clr     (sticky_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: named flag bits, plain integer counter.
  bit m_n, m_c, m_v, m_z;
  bit m_ov, m_ct, m_sticky;
  int m_cnt;
  bit m_live = 1'b0;

  function automatic bit cond_eval(input int code, input bit n, input bit c, input bit v,
                                   input bit z);
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_c = 0; m_v = 0; m_z = 1;
      m_ov = 0; m_ct = 0; m_sticky = 0; m_cnt = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      bit ev;
      ev = upd_valid && upd_mask[1] && v_in;
      if (upd_valid) begin
        if (upd_mask[3]) m_n = n_in;
        if (upd_mask[2]) m_c = c_in;
        if (upd_mask[1]) m_v = v_in;
        if (upd_mask[0]) m_z = z_in;
      end
      m_ov = cond_valid;
      if (cond_valid) m_ct = cond_eval(int'(cond_code), m_n, m_c, m_v, m_z);
      if (ev) begin
        m_sticky = 1;
        m_cnt = sticky_clr ? 1 : ((m_cnt < CntSat) ? m_cnt + 1 : CntSat);
      end else if (sticky_clr) begin
        m_sticky = 0;
        m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_flags", int'(flags), int'({m_n, m_c, m_v, m_z}));
      chk("model_cond_out_valid", int'(cond_out_valid), int'(m_ov));
      if (m_ov) chk("model_cond_true", int'(cond_true), int'(m_ct));
      chk("model_v_sticky", int'(v_sticky), int'(m_sticky));
      chk("model_v_count", int'(v_count), m_cnt);
    end
  end

  task automatic idle_inputs();
    rst = 0; upd_valid = 0; upd_mask = 4'b0000;
    n_in = 0; c_in = 0; v_in = 0; z_in = 0;
    cond_valid = 0; cond_code = 4'd0; sticky_clr = 0;
  endtask

  // Inputs are applied now, held across the next rising edge, and this returns at the
  // following falling edge where the registered result can be sampled.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic upd(input logic [3:0] mask, input logic [3:0] nczv);
    upd_valid = 1; upd_mask = mask;
    {n_in, c_in, v_in, z_in} = nczv;
  endtask

  task automatic cond(input int code);
    cond_valid = 1; cond_code = 4'(code);
  endtask

  initial begin
    int exp_sig[8];
    int code_sig[8];
    int exp_cnt[5];
    idle_inputs();
    rst = 1;
    tick();
    tick();
    idle_inputs();
    chk("reset_flags", int'(flags), 1);
    chk("reset_v_count", int'(v_count), 0);
    chk("reset_v_sticky", int'(v_sticky), 0);
    chk("reset_cond_out_valid", int'(cond_out_valid), 0);
    tick();
    cond(0); tick(); idle_inputs();
    chk("eq_after_reset_valid", int'(cond_out_valid), 1);
    chk("eq_after_reset_true", int'(cond_true), 1);

    upd(4'b1111, 4'b1100); cond(4); tick(); idle_inputs();
    chk("fwd_mi_flags", int'(flags), 4'b1100);
    chk("fwd_mi_true", int'(cond_true), 1);

    rst = 1; tick(); idle_inputs();
    upd(4'b0100, 4'b1100); tick(); idle_inputs();
    chk("mask_c_only_flags", int'(flags), 4'b0101);
    cond(8); tick(); idle_inputs();
    chk("hi_false", int'(cond_true), 0);

    upd(4'b1111, 4'b0110); tick(); idle_inputs();
    chk("signed_flags", int'(flags), 4'b0110);
    code_sig = '{11, 10, 12, 13, 2, 6, 14, 15};
    exp_sig  = '{1, 0, 0, 1, 1, 1, 1, 0};
    foreach (code_sig[i]) begin
      cond(code_sig[i]); tick(); idle_inputs();
      chk($sformatf("signed_code_%0d", code_sig[i]), int'(cond_true), exp_sig[i]);
    end

    upd(4'b1111, 4'b1000); tick(); idle_inputs();
    cond(0); tick();
    chk("b2b_eq", int'(cond_true), 0);
    chk("b2b_valid0", int'(cond_out_valid), 1);
    cond(1); tick();
    chk("b2b_ne", int'(cond_true), 1);
    chk("b2b_valid1", int'(cond_out_valid), 1);
    cond(14); tick(); idle_inputs();
    chk("b2b_al", int'(cond_true), 1);
    chk("b2b_valid2", int'(cond_out_valid), 1);
    tick();
    chk("b2b_valid_drop", int'(cond_out_valid), 0);

    sticky_clr = 1; tick(); idle_inputs();
    chk("pre_sat_clear", int'(v_count), 0);
    exp_cnt = '{1, 2, 3, 3, 3};
    foreach (exp_cnt[i]) begin
      upd(4'b0010, 4'b0010); tick(); idle_inputs();
      chk($sformatf("sat_count_%0d", i), int'(v_count), exp_cnt[i]);
    end
    chk("sat_sticky", int'(v_sticky), 1);
    upd(4'b0000, 4'b0010); tick(); idle_inputs();
    chk("unmasked_v_no_event", int'(v_count), 3);
    upd(4'b0010, 4'b0010); sticky_clr = 1; tick(); idle_inputs();
    chk("clr_with_event_count", int'(v_count), 1);
    chk("clr_with_event_sticky", int'(v_sticky), 1);
    sticky_clr = 1; tick(); idle_inputs();
    chk("clr_alone_count", int'(v_count), 0);
    chk("clr_alone_sticky", int'(v_sticky), 0);

    upd(4'b1111, 4'b1110); cond(14); tick(); idle_inputs();
    rst = 1; upd(4'b1111, 4'b1110); cond(14); tick(); idle_inputs();
    chk("rst_mid_flags", int'(flags), 1);
    chk("rst_mid_v_count", int'(v_count), 0);
    chk("rst_mid_cond_out_valid", int'(cond_out_valid), 0);

    for (int k = 0; k < 3000; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      upd_valid  = $urandom_range(0, 1);
      upd_mask   = 4'($urandom);
      {n_in, c_in, v_in, z_in} = 4'($urandom);
      cond_valid = ($urandom_range(0, 3) != 0);
      cond_code  = 4'($urandom);
      sticky_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nzcv_status_reg.md
Name: nzcv_status_reg

Overview:
- Registered NZCV status stage directly downstream of the adder + flag_circuit pair.
- Captures the combinational n/c/v/z flags under a per-flag write mask.
- Evaluates 4-bit condition codes against the current flags and returns a registered taken/not-taken result.
- Counts overflow events in a saturating counter with a sticky overflow bit, for branch and exception logic.

Parameters:
- CNT_W, 8, width of the saturating overflow event counter (min 1).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- upd_valid  in  1  flag update strobe.
- upd_mask  in  4  per-flag write enable, bit order {N,C,V,Z}.
- n_in  in  1  negative flag from flag_circuit.
- c_in  in  1  carry flag from flag_circuit.
- v_in  in  1  overflow flag from flag_circuit.
- z_in  in  1  zero flag from flag_circuit.
- cond_valid  in  1  condition evaluation request.
- cond_code  in  4  condition selector, encoding below.
- cond_out_valid  out  1  registered; high exactly 1 cycle after an accepted request.
- cond_true  out  1  registered condition result; valid when cond_out_valid=1.
- flags  out  4  current {N,C,V,Z} register.
- v_sticky  out  1  set by any written V=1, cleared only by sticky_clr or rst.
- v_count  out  CNT_W  saturating count of written V=1 events.
- sticky_clr  in  1  clears v_sticky and v_count.

Behaviour:
- Reset is sampled on clk rising edge while rst=1. Reset values:
  - flags=4'b0001 (Z=1, matching a zero result).
  - cond_out_valid=0, cond_true=0, v_sticky=0, v_count=0.
  - rst overrides every other input in the same cycle.
  - A request pending on the reset edge is dropped: no cond_out_valid follows.
- Flag update: on an edge with upd_valid=1, each flags bit whose upd_mask bit is 1 loads its *_in value. Unmasked bits hold.
  - upd_valid=0 or upd_mask=0: no change.
  - Latency: new flags are visible on the flags output 1 cycle after the strobe.
- Effective flags (F): the value flags will take after this cycle's update, i.e. the masked merge of the current register and *_in when upd_valid=1, otherwise the register.
- Condition evaluation:
  - On an edge with cond_valid=1: cond_true <= eval(cond_code, F) and cond_out_valid <= 1.
  - On an edge with cond_valid=0: cond_out_valid <= 0 and cond_true holds its last value.
  - Throughput: 1 request per cycle, no backpressure.
  - A same-cycle update is forwarded: the condition sees the new flags, never the stale ones.
- Condition code encoding:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z & (N==V)
  - 13 LE: Z | (N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Overflow event: upd_valid & upd_mask[1] & v_in.
  - Unmasked V or upd_valid=0: no event, even when v_in=1.
- Counter and sticky bit:
  - Each event sets v_sticky and increments v_count.
  - v_count saturates at 2^CNT_W-1 and never wraps.
  - v_sticky stays 1 while saturated.
- sticky_clr: clears both on the next edge.
  - sticky_clr together with an event: the event wins over the clear, giving v_count=1 and v_sticky=1.
- Arithmetic: v_count is an unsigned increment with a compare against all-ones before the add. The implementation carries no wider intermediate.

Test Plan:
- Reset and hold:
  - Stimulus: rst=1 for 2 cycles, then idle.
  - Required: flags=0001, v_count=0, v_sticky=0, cond_out_valid=0.
  - Stimulus: cond EQ with no update.
  - Required: 1 cycle later cond_out_valid=1, cond_true=1.
- Masked update with forwarding:
  - Stimulus: same cycle as an update n,c,v,z=1,1,0,0 with mask=1111, cond MI (4).
  - Required: next cycle flags=1100, cond_true=1.
  - Stimulus: same update with mask=0100.
  - Required: flags=0101, then cond HI (8) gives 0.
- Signed conditions:
  - Stimulus: load flags 0110 (C=1, V=1).
  - Required: LT=1, GE=0, GT=0, LE=1, CS=1, VS=1, AL=1, NV=0.
- Back-to-back requests:
  - Stimulus: cond_valid high 3 cycles with codes EQ, NE, AL while flags=1000.
  - Required: cond_true sequence 0, 1, 1 on consecutive cycles, and cond_out_valid high for exactly 3 cycles.
- Counter saturation and clear:
  - Stimulus: CNT_W=2, 5 updates with v_in=1, mask=0010.
  - Required: v_count 1, 2, 3, 3, 3; v_sticky=1.
  - Stimulus: v_in=1 with mask=0000.
  - Required: count unchanged.
  - Stimulus: sticky_clr together with an event.
  - Required: v_count=1, v_sticky=1.
  - Stimulus: sticky_clr alone.
  - Required: v_count=0, v_sticky=0.
- Reset mid-operation:
  - Stimulus: rst asserted together with upd_valid, cond_valid and an event.
  - Required: next cycle flags=0001, v_count=0, cond_out_valid=0.
